// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALTED control with jump, branch and halt handling.
// Optional retired-instruction counter enabled by the PC_SEQ_RETIRE_CNT_EN macro.
module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic [3:0]  opcode,
    input  logic        br_cond,
    input  logic [15:0] br_off,
    input  logic [15:0] jmp_tgt,
    output logic [15:0] pc,
    output logic        running,
    output logic        halted
`ifdef PC_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0] retired
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'b0010;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1110;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] pc_r;
    logic [15:0] pc_next_s;
    logic        running_r;
    logic        halted_r;

    // Next-state and next-pc selection; stall freezes everything in RUN.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        case (state_r)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_next_s = ST_RUN;
                    pc_next_s    = 16'h0000;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    case (opcode)
                        OP_HALT: begin
                            state_next_s = ST_HALTED;
                        end
                        OP_JMP: begin
                            pc_next_s = jmp_tgt;
                        end
                        OP_BNE, OP_BEQ, OP_BLT: begin
                            if (br_cond) begin
                                pc_next_s = pc_r + br_off;
                            end else begin
                                pc_next_s = pc_r + 16'd1;
                            end
                        end
                        default: begin
                            pc_next_s = pc_r + 16'd1;
                        end
                    endcase
                end else begin
                    pc_next_s = pc_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                pc_next_s    = 16'h0000;
            end
        endcase
    end

    // State, pc and status flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= 16'h0000;
            running_r <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pc_r      <= pc_next_s;
            running_r <= (state_next_s == ST_RUN);
            halted_r  <= (state_next_s == ST_HALTED);
        end
    end

    assign pc      = pc_r;
    assign running = running_r;
    assign halted  = halted_r;

`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [15:0] retired_r;
    logic        cnt_clr_s;
    logic        cnt_inc_s;

    // Counter controls: clear on launch, count every non-stalled RUN cycle (HALT included).
    always_comb begin
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        if (state_r == ST_RUN) begin
            cnt_inc_s = !stall;
        end else begin
            cnt_clr_s = start;
        end
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_r <= 16'h0000;
        end else if (cnt_clr_s) begin
            retired_r <= 16'h0000;
        end else if (cnt_inc_s) begin
            retired_r <= retired_r + 16'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign retired = retired_r;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed steps push expected outputs,
// an independent negedge monitor pops and compares them.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic [3:0]  opcode;
    logic        br_cond;
    logic [15:0] br_off;
    logic [15:0] jmp_tgt;
    logic [15:0] pc;
    logic        running;
    logic        halted;
`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] LIM  = 4'b0001;
    localparam logic [3:0] JMP  = 4'b0010;
    localparam logic [3:0] INC  = 4'b0100;
    localparam logic [3:0] SFT  = 4'b0101;
    localparam logic [3:0] MVF  = 4'b0110;
    localparam logic [3:0] BNE  = 4'b1010;
    localparam logic [3:0] BEQ  = 4'b1011;
    localparam logic [3:0] BLT  = 4'b1100;
    localparam logic [3:0] HALT = 4'b1110;
    localparam logic [3:0] TBA  = 4'b1111;

    typedef struct {
        int          cyc;
        logic [15:0] pc;
        logic        run;
        logic        hlt;
        logic [15:0] ret;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_cnt = 0;
    int   total   = 0;
    int   bad     = 0;

    pc_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stall   (stall),
        .opcode  (opcode),
        .br_cond (br_cond),
        .br_off  (br_off),
        .jmp_tgt (jmp_tgt),
        .pc      (pc),
        .running (running),
        .halted  (halted)
`ifdef PC_SEQ_RETIRE_CNT_EN
        ,
        .retired (retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to tag when each expectation becomes due.
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc_cnt);
        end
    endtask

    // Monitor: pop every expectation due this cycle and compare against the DUT.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            e = exp_q.pop_front();
            if (e.cyc != cyc_cnt) begin
                chk({e.nm, "_stale"}, 16'(cyc_cnt), 16'(e.cyc));
            end else begin
                chk({e.nm, "_pc"}, pc, e.pc);
                chk({e.nm, "_running"}, {15'd0, running}, {15'd0, e.run});
                chk({e.nm, "_halted"}, {15'd0, halted}, {15'd0, e.hlt});
`ifdef PC_SEQ_RETIRE_CNT_EN
                chk({e.nm, "_retired"}, retired, e.ret);
`endif
            end
        end
    end

    // Apply one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic rs, input logic st, input logic sl, input logic [3:0] op,
                        input logic bc, input logic [15:0] bo, input logic [15:0] jt,
                        input logic [15:0] e_pc, input logic e_run, input logic e_hlt,
                        input logic [15:0] e_ret, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset   = rs;
        start   = st;
        stall   = sl;
        opcode  = op;
        br_cond = bc;
        br_off  = bo;
        jmp_tgt = jt;
        e.cyc = cyc_cnt + 1;
        e.pc  = e_pc;
        e.run = e_run;
        e.hlt = e_hlt;
        e.ret = e_ret;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stall = 1'b0; opcode = ADD;
        br_cond = 1'b0; br_off = 16'h0000; jmp_tgt = 16'h0000;

        // rs st sl op br_c br_off jmp_tgt | pc run hlt ret
        step(1'b1, 1'b0, 1'b0, ADD,  1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0, "reset0");
        step(1'b1, 1'b0, 1'b0, ADD,  1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0, "reset1");
        step(1'b0, 1'b1, 1'b0, ADD,  1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'd0, "start");
        step(1'b0, 1'b0, 1'b0, LIM,  1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'd1, "seq_lim");
        step(1'b0, 1'b0, 1'b0, INC,  1'b0, 16'h0000, 16'h0000, 16'h0002, 1'b1, 1'b0, 16'd2, "seq_inc");
        step(1'b0, 1'b0, 1'b0, LIM,  1'b0, 16'h0000, 16'h0000, 16'h0003, 1'b1, 1'b0, 16'd3, "seq_lim2");
        step(1'b0, 1'b0, 1'b0, SFT,  1'b0, 16'h0000, 16'h0000, 16'h0004, 1'b1, 1'b0, 16'd4, "seq_sft");
        step(1'b0, 1'b0, 1'b0, MVF,  1'b0, 16'h0000, 16'h0000, 16'h0005, 1'b1, 1'b0, 16'd5, "seq_mvf");
        step(1'b0, 1'b0, 1'b0, HALT, 1'b0, 16'h0000, 16'h0000, 16'h0005, 1'b0, 1'b1, 16'd6, "halt");
        step(1'b0, 1'b0, 1'b0, JMP,  1'b0, 16'h0000, 16'h1234, 16'h0005, 1'b0, 1'b1, 16'd6, "halted_ign");
        step(1'b0, 1'b1, 1'b0, ADD,  1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'd0, "restart");
        step(1'b0, 1'b0, 1'b0, ADD,  1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'd1, "add1");
        step(1'b0, 1'b0, 1'b0, ADD,  1'b0, 16'h0000, 16'h0000, 16'h0002, 1'b1, 1'b0, 16'd2, "add2");
        step(1'b0, 1'b0, 1'b0, ADD,  1'b0, 16'h0000, 16'h0000, 16'h0003, 1'b1, 1'b0, 16'd3, "add3");
        step(1'b0, 1'b0, 1'b0, JMP,  1'b0, 16'h0000, 16'h0040, 16'h0040, 1'b1, 1'b0, 16'd4, "jmp40");
        step(1'b0, 1'b0, 1'b0, JMP,  1'b0, 16'h0000, 16'h000A, 16'h000A, 1'b1, 1'b0, 16'd5, "jmp10");
        step(1'b0, 1'b0, 1'b0, BEQ,  1'b1, 16'hFFFC, 16'h0000, 16'h0006, 1'b1, 1'b0, 16'd6, "beq_taken");
        step(1'b0, 1'b0, 1'b0, JMP,  1'b0, 16'h0000, 16'h000A, 16'h000A, 1'b1, 1'b0, 16'd7, "jmp10b");
        step(1'b0, 1'b0, 1'b0, BEQ,  1'b0, 16'hFFFC, 16'h0000, 16'h000B, 1'b1, 1'b0, 16'd8, "beq_not");
        step(1'b0, 1'b0, 1'b0, BNE,  1'b1, 16'h0005, 16'h0000, 16'h0010, 1'b1, 1'b0, 16'd9, "bne_taken");
        step(1'b0, 1'b0, 1'b0, BLT,  1'b0, 16'h0005, 16'h0000, 16'h0011, 1'b1, 1'b0, 16'd10, "blt_not");
        step(1'b0, 1'b0, 1'b0, TBA,  1'b1, 16'h0005, 16'h0000, 16'h0012, 1'b1, 1'b0, 16'd11, "tba");
        step(1'b0, 1'b0, 1'b0, JMP,  1'b0, 16'h0000, 16'h0007, 16'h0007, 1'b1, 1'b0, 16'd12, "jmp7");
        step(1'b0, 1'b0, 1'b1, JMP,  1'b0, 16'h0000, 16'h0100, 16'h0007, 1'b1, 1'b0, 16'd12, "stall1");
        step(1'b0, 1'b0, 1'b1, JMP,  1'b0, 16'h0000, 16'h0100, 16'h0007, 1'b1, 1'b0, 16'd12, "stall2");
        step(1'b0, 1'b0, 1'b1, JMP,  1'b0, 16'h0000, 16'h0100, 16'h0007, 1'b1, 1'b0, 16'd12, "stall3");
        step(1'b0, 1'b0, 1'b0, JMP,  1'b0, 16'h0000, 16'h0100, 16'h0100, 1'b1, 1'b0, 16'd13, "stall_rel");
        step(1'b0, 1'b0, 1'b0, JMP,  1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'd14, "jmp_ffff");
        step(1'b0, 1'b0, 1'b0, ADD,  1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'd15, "pc_wrap");
        step(1'b0, 1'b0, 1'b0, BLT,  1'b1, 16'hFFFE, 16'h0000, 16'hFFFE, 1'b1, 1'b0, 16'd16, "br_wrap");
        step(1'b0, 1'b0, 1'b0, JMP,  1'b0, 16'h0000, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0, 16'd17, "self_jmp1");
        step(1'b0, 1'b0, 1'b0, JMP,  1'b0, 16'h0000, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0, 16'd18, "self_jmp2");
        step(1'b0, 1'b1, 1'b0, ADD,  1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'd19, "start_in_run");
        step(1'b0, 1'b0, 1'b0, JMP,  1'b0, 16'h0000, 16'h0009, 16'h0009, 1'b1, 1'b0, 16'd20, "jmp9");
        step(1'b1, 1'b1, 1'b1, JMP,  1'b1, 16'h0003, 16'h0055, 16'h0000, 1'b0, 1'b0, 16'd0, "reset_mid");
        step(1'b0, 1'b0, 1'b0, ADD,  1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0, "idle_ign");
        step(1'b0, 1'b1, 1'b0, ADD,  1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'd0, "start2");
        step(1'b0, 1'b0, 1'b0, ADD,  1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'd1, "add_after");
        step(1'b0, 1'b0, 1'b1, HALT, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'd1, "halt_stall");
        step(1'b0, 1'b0, 1'b0, HALT, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'd2, "halt2");

        @(posedge clk);
        #1;
        opcode = ADD;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
